// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, default width.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Divides occupy the upper half of the op encoding.
    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // MULT and DIV treat operands as two's complement.
    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: magnitude of a signed operand, or sign fix-up of a result.
// Latency: purely combinational.
// Backpressure: none.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with the HI/LO pair; MTHI/MTLO write HI/LO directly when idle.
// Latency: busy E0..E33, done pulses after E33; with MULDIV_EARLY_OUT_EN a zero-divisor divide finishes at E1.
// Backpressure: none; start/mthi/mtlo are ignored while busy, the pipeline stalls on busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e             state, state_nxt;
    op_e                op_in;
    logic               signed_in, is_div_in, zero_div_in;
    logic               sgn_a_in, sgn_b_in;
    logic               accept, early_out;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic               is_div_q, neg_res_q, neg_a_q, dz_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   dvs;        // multiplicand / divisor magnitude
    logic [2*WIDTH-1:0] acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}

    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_in       = op_e'(op);
    assign signed_in   = op_is_signed(op_in);
    assign is_div_in   = op_is_div(op_in);
    assign zero_div_in = is_div_in && (input2 == '0);
    assign sgn_a_in    = signed_in & input1[WIDTH-1];
    assign sgn_b_in    = signed_in & input2[WIDTH-1];
    assign busy        = (state != ST_IDLE);

`ifdef MULDIV_EARLY_OUT_EN
    // A zero divisor has a fixed answer, so skip the iterations entirely.
    assign early_out = zero_div_in;
`else
    assign early_out = 1'b0;
`endif

    // Operand magnitudes; the iteration itself is always unsigned.
    muldiv_signfix #(.W(WIDTH)) u_abs_a (.din(input1), .neg(sgn_a_in), .dout(abs_a));
    muldiv_signfix #(.W(WIDTH)) u_abs_b (.din(input2), .neg(sgn_b_in), .dout(abs_b));

    // Result sign fix-up: full product, quotient by sign mismatch, remainder by dividend sign.
    muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.din(acc), .neg(neg_res_q), .dout(prod_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_quo (.din(acc[WIDTH-1:0]), .neg(neg_res_q), .dout(quo_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_rem (.din(acc[2*WIDTH-1:WIDTH]), .neg(neg_a_q), .dout(rem_fix));

    // One shift-add step and one restoring divide step, selected by the latched op.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
        mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
        if (div_trial[WIDTH])
            div_nxt = {acc[2*WIDTH-2:0], 1'b0};
        else
            div_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: accept start only when idle, WIDTH iterations, then one fix-up cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = early_out ? ST_FIX : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == CW'(WIDTH - 1))
                    state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture on accept and the iterative datapath during CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            dz_q      <= 1'b0;
            cnt       <= '0;
            dvs       <= '0;
            acc       <= '0;
        end else if (accept) begin
            is_div_q  <= is_div_in;
            neg_res_q <= sgn_a_in ^ sgn_b_in;
            neg_a_q   <= sgn_a_in;
            dz_q      <= zero_div_in;
            cnt       <= '0;
            dvs       <= abs_b;
            // Early-out preloads what the full zero-divisor run would leave: remainder |a|, quotient all ones.
            acc       <= early_out ? {abs_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, abs_a};
        end else if (state == ST_CALC) begin
            cnt       <= cnt + CW'(1);
            acc       <= is_div_q ? div_nxt : mul_nxt;
        end
    end

    // Architectural HI/LO, done pulse and divide-by-zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done <= (state == ST_FIX);
            if (state == ST_FIX) begin
                if (is_div_q) begin
                    // Zero divisor: remainder fix-up restores input1, quotient forced to all ones.
                    hi <= rem_fix;
                    lo <= dz_q ? {WIDTH{1'b1}} : quo_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
                if (is_div_q && dz_q)
                    divZero <= 1'b1;
            end else if (accept) begin
                divZero <= 1'b0;
            end else if (state == ST_IDLE) begin
                if (mthi)
                    hi <= wdata;
                if (mtlo)
                    lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed check of muldiv_unit against an arithmetic reference model.
// Latency: checks done arrives after E33 (E1 for zero-divisor divide when early-out is built in).
// Backpressure: checks start/mthi are ignored while busy and that reset aborts an op.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] input1, input2, wdata;
    logic        mthi, mtlo;
    logic        busy, done, divZero;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .input1  (input1),
        .input2  (input2),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .divZero (divZero),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint     sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'b01: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    h = a; l = 32'hFFFF_FFFF; dz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    p = q; l = p[31:0];
                    p = r; h = p[31:0];
                end else begin
                    l = a / b; h = a % b;
                end
            end
        endcase
    endfunction

    // Launch one op, follow it to done and compare against the model.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit with_mthi, input bit tail);
        logic [31:0] eh, el, h0, l0;
        logic        edz;
        int          lat, exp_lat, busy_cnt, moved;
        model(o, a, b, eh, el, edz);
        exp_lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
        if (o[1] && b == 32'h0) exp_lat = 1;
`endif
        @(negedge clk);
        h0 = hi; l0 = lo;
        start = 1'b1; op = o; input1 = a; input2 = b;
        if (with_mthi) begin mthi = 1'b1; wdata = 32'hAA; end
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        lat = 0; busy_cnt = 0; moved = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (hi !== h0 || lo !== l0) moved++;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_cnt, exp_lat);
        check("hilo_hold", moved, 0);
        check("hi", hi, eh);
        check("lo", lo, el);
        check("divZero", divZero, edz);
        check("busy_at_done", busy, 0);
        if (tail) begin
            @(posedge clk); #1;
            check("done_pulse", done, 0);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  o;
        int          sel, dcnt;

        rst_n = 1'b1; start = 1'b0; op = 2'b00; input1 = '0; input2 = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_divZero", divZero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed cases.
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1);
        run_op(2'b11, 32'd7, 32'd2, 0, 1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
        run_op(2'b11, 32'd5, 32'd0, 0, 1);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 0, 0);
        // Back-to-back start in the done cycle; also clears divZero.
        run_op(2'b01, 32'd3, 32'd4, 0, 1);

        // mthi/mtlo when idle, both together.
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555_0000;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        check("mt_both_hi", hi, 32'h5555_0000);
        check("mt_both_lo", lo, 32'h5555_0000);
        // start wins over mthi in the same cycle (hold check sees the dropped write).
        run_op(2'b01, 32'd9, 32'd9, 1, 1);

        // Random ops.
        for (int i = 0; i < 48; i++) begin
            o = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            a = (sel == 3) ? 32'h8000_0000 : $urandom;
            case (sel)
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(o, a, b, 0, (i % 2) == 0);
        end

        // Ignored start/mthi while busy, then abort by reset.
        @(negedge clk);
        start = 1'b1; op = 2'b01; input1 = 32'd3; input2 = 32'd4;
        @(posedge clk); #1 start = 1'b0;
        a = hi;
        repeat (4) @(posedge clk);
        @(negedge clk); start = 1'b1; mthi = 1'b1; wdata = 32'hAA; op = 2'b11;
        @(negedge clk); start = 1'b0; mthi = 1'b0;
        check("busy_ign_hi", hi, a);
        check("busy_still", busy, 1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        dcnt = 0;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        @(negedge clk); mtlo = 1'b1; wdata = 32'h1234;
        @(negedge clk); mtlo = 1'b0;
        check("mtlo_after_rst", lo, 32'h1234);
        check("mtlo_hi_kept", hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
